// File: rtl/mem_io_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_access_sequencer
// Description : Multi-cycle load/store sequencer. Runs data RAM accesses
//               (fixed read latency) and MMIO accesses (ready handshake),
//               stalls the PC while an access is in flight, latches load
//               data and reports IO timeouts as a bus error.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_access_sequencer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int RAM_LAT    = 1,
    parameter int IO_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              io_read,
    input  logic              io_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [DATA_W-1:0] io_rdata,
    input  logic              io_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic              io_rd_stb,
    output logic              io_wr_stb,
    output logic [ADDR_W-1:0] acc_addr,
    output logic [DATA_W-1:0] acc_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              bus_err
);

    // RAM_LAT is limited to 1..15, so a 4-bit down-counter always fits.
    localparam int CNT_W  = 4;
    // The timeout counter only ever reaches IO_TIMEOUT-1 before aborting.
    localparam int TCNT_W = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0]  c_ram_lat   = CNT_W'(RAM_LAT);
    localparam logic [TCNT_W-1:0] c_tcnt_last = TCNT_W'((IO_TIMEOUT > 0) ? IO_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RAM_ACC = 2'd1,
        S_IO_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [TCNT_W-1:0]   r_tcnt;
    logic                r_is_write;
    logic                r_err;
    logic [ADDR_W-1:0]   r_acc_addr;
    logic [DATA_W-1:0]   r_acc_wdata;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_req_ram;
    logic                w_req_io;
    logic                w_io_timeout;

    assign w_req_ram    = mem_read | mem_write;
    assign w_req_io     = io_read | io_write;
    // Equality test before increment, so the counter never wraps; 0 disables.
    assign w_io_timeout = (IO_TIMEOUT != 0) && (r_tcnt == c_tcnt_last);

    assign acc_addr  = r_acc_addr;
    assign acc_wdata = r_acc_wdata;
    assign rdata     = r_rdata;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode; rst_n gates stall so it drops immediately.
    always_comb begin
        w_state_nxt = r_state;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        io_rd_stb   = 1'b0;
        io_wr_stb   = 1'b0;
        stall       = 1'b0;
        rdata_valid = 1'b0;
        bus_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_io) begin
                    // IO wins when both kinds are requested.
                    stall       = rst_n;
                    w_state_nxt = S_IO_WAIT;
                end else if (w_req_ram) begin
                    stall       = rst_n;
                    w_state_nxt = S_RAM_ACC;
                end
            end
            S_RAM_ACC: begin
                stall  = rst_n;
                // Counter still holds its entry value only in the first cycle.
                ram_en = (r_cnt == c_ram_lat);
                ram_we = (r_cnt == c_ram_lat) & r_is_write;
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_IO_WAIT: begin
                stall     = rst_n;
                io_rd_stb = ~r_is_write;
                io_wr_stb = r_is_write;
                if (io_ready || w_io_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                rdata_valid = ~r_is_write;
                bus_err     = r_err;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Access latching, latency/timeout counters and load-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_tcnt      <= '0;
            r_is_write  <= 1'b0;
            r_err       <= 1'b0;
            r_acc_addr  <= '0;
            r_acc_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_io || w_req_ram) begin
                        r_acc_addr  <= addr;
                        r_acc_wdata <= wdata;
                        r_is_write  <= w_req_io ? io_write : mem_write;
                        r_cnt       <= c_ram_lat;
                        r_tcnt      <= '0;
                        r_err       <= 1'b0;
                    end
                end
                S_RAM_ACC: begin
                    if (r_cnt == '0) begin
                        if (!r_is_write) begin
                            r_rdata <= ram_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_IO_WAIT: begin
                    if (io_ready) begin
                        if (!r_is_write) begin
                            r_rdata <= io_rdata;
                        end
                    end else if (w_io_timeout) begin
                        if (!r_is_write) begin
                            r_rdata <= '1;
                        end
                        r_err <= 1'b1;
                    end else if (IO_TIMEOUT != 0) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_io_access_sequencer
// Description : Directed self-checking bench for mem_io_access_sequencer
//               (RAM_LAT=1, IO_TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_access_sequencer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst_n;
    logic              mem_read, mem_write, io_read, io_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, ram_rdata, io_rdata;
    logic              io_ready;
    logic              ram_en, ram_we, io_rd_stb, io_wr_stb, stall;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata, rdata;
    logic              rdata_valid, bus_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_ram_en = 0;
    int n_valid  = 0;
    int n_err    = 0;

    mem_io_access_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_LAT(1), .IO_TIMEOUT(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write),
        .io_read(io_read), .io_write(io_write),
        .addr(addr), .wdata(wdata),
        .ram_rdata(ram_rdata), .io_rdata(io_rdata), .io_ready(io_ready),
        .ram_en(ram_en), .ram_we(ram_we),
        .io_rd_stb(io_rd_stb), .io_wr_stb(io_wr_stb),
        .acc_addr(acc_addr), .acc_wdata(acc_wdata),
        .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (ram_en)      n_ram_en++;
        if (rdata_valid) n_valid++;
        if (bus_err)     n_err++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        io_read   = 1'b0;
        io_write  = 1'b0;
    endtask

    int base_ram_en, base_valid, base_err, stb_cycles, guard;

    initial begin
        rst_n     = 1'b0;
        clear_req();
        addr      = '0;
        wdata     = '0;
        ram_rdata = 32'hDEADBEEF;
        io_rdata  = 32'hDEADBEEF;
        io_ready  = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_stall", stall, 0);
        check("rst_rdata", rdata, 0);
        check("rst_acc_addr", acc_addr, 0);
        check("rst_ram_en", ram_en, 0);
        rst_n = 1'b1;
        tick();

        // RAM load, RAM_LAT=1
        mem_read = 1'b1; addr = 32'h100; #1;
        check("ld_c0_stall", stall, 1);
        check("ld_c0_ram_en", ram_en, 0);
        tick(); clear_req(); addr = 32'h0; #1;
        check("ld_c1_ram_en", ram_en, 1);
        check("ld_c1_ram_we", ram_we, 0);
        check("ld_c1_stall", stall, 1);
        check("ld_c1_acc_addr", acc_addr, 32'h100);
        tick(); ram_rdata = 32'h12345678; #1;
        check("ld_c2_ram_en", ram_en, 0);
        check("ld_c2_stall", stall, 1);
        tick(); ram_rdata = 32'hDEADBEEF; #1;
        check("ld_c3_rdata", rdata, 32'h12345678);
        check("ld_c3_valid", rdata_valid, 1);
        check("ld_c3_stall", stall, 0);
        tick(); #1;
        check("ld_c4_valid", rdata_valid, 0);
        check("ld_c4_rdata_hold", rdata, 32'h12345678);

        // RAM store
        base_valid = n_valid;
        mem_write = 1'b1; addr = 32'h200; wdata = 32'hA5A5A5A5; #1;
        check("st_c0_stall", stall, 1);
        tick(); clear_req(); wdata = 32'h0; ram_rdata = 32'h0BADF00D; #1;
        check("st_c1_ram_en", ram_en, 1);
        check("st_c1_ram_we", ram_we, 1);
        check("st_c1_acc_wdata", acc_wdata, 32'hA5A5A5A5);
        check("st_c1_acc_addr", acc_addr, 32'h200);
        tick(); #1;
        check("st_c2_stall", stall, 1);
        tick(); #1;
        check("st_c3_stall", stall, 0);
        check("st_c3_valid", rdata_valid, 0);
        check("st_c3_rdata", rdata, 32'h12345678);
        tick(); #1;
        check("st_no_valid", n_valid - base_valid, 0);

        // IO read, ready in the 4th strobe cycle
        base_ram_en = n_ram_en;
        io_read = 1'b1; addr = 32'hFFFFFC70; #1;
        check("ior_c0_stall", stall, 1);
        check("ior_c0_stb", io_rd_stb, 0);
        stb_cycles = 0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) clear_req();
            if (c == 4) begin io_ready = 1'b1; io_rdata = 32'h000000FF; end
            #1;
            if (io_rd_stb && stall) stb_cycles++;
        end
        check("ior_stb_cycles", stb_cycles, 4);
        check("ior_acc_addr", acc_addr, 32'hFFFFFC70);
        tick(); io_ready = 1'b0; io_rdata = 32'hDEADBEEF; #1;
        check("ior_done_stb", io_rd_stb, 0);
        check("ior_done_rdata", rdata, 32'hFF);
        check("ior_done_valid", rdata_valid, 1);
        check("ior_done_err", bus_err, 0);
        check("ior_done_stall", stall, 0);
        check("ior_no_ram_en", n_ram_en - base_ram_en, 0);
        tick();

        // IO write, never ready -> timeout after 8 strobe cycles
        base_valid = n_valid;
        io_write = 1'b1; addr = 32'hFFFFFC80; wdata = 32'h11223344; #1;
        tick(); clear_req(); #1;
        stb_cycles = 0;
        guard = 0;
        while (stall && guard < 40) begin
            if (io_wr_stb) stb_cycles++;
            tick(); #1;
            guard++;
        end
        check("iow_no_hang", guard < 40, 1);
        check("iow_stb_cycles", stb_cycles, 8);
        check("iow_done_err", bus_err, 1);
        check("iow_done_stall", stall, 0);
        check("iow_done_stb", io_wr_stb, 0);
        check("iow_done_valid", rdata_valid, 0);
        check("iow_rdata_hold", rdata, 32'hFF);
        tick(); #1;
        check("iow_err_pulse_end", bus_err, 0);
        check("iow_no_valid", n_valid - base_valid, 0);

        // IO read, ready arrives exactly on the timeout cycle: ready wins
        io_read = 1'b1; addr = 32'hFFFFFC90; #1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) clear_req();
            if (c == 8) begin io_ready = 1'b1; io_rdata = 32'h00000077; end
            #1;
        end
        check("race_stb_c8", io_rd_stb, 1);
        tick(); io_ready = 1'b0; #1;
        check("race_rdata", rdata, 32'h77);
        check("race_valid", rdata_valid, 1);
        check("race_err", bus_err, 0);
        tick();

        // mem_read and io_read together: IO path only
        base_ram_en = n_ram_en;
        mem_read = 1'b1; io_read = 1'b1; addr = 32'h300; #1;
        tick(); clear_req(); io_ready = 1'b1; io_rdata = 32'h00000055; #1;
        check("both_stb", io_rd_stb, 1);
        check("both_ram_en", ram_en, 0);
        tick(); io_ready = 1'b0; #1;
        check("both_rdata", rdata, 32'h55);
        check("both_valid", rdata_valid, 1);
        tick(); #1;
        check("both_no_ram_en", n_ram_en - base_ram_en, 0);

        // Async reset in IO_WAIT cycle 2
        io_read = 1'b1; addr = 32'h400; #1;
        tick(); clear_req(); #1;
        tick(); #1;
        check("rstmid_stb_before", io_rd_stb, 1);
        base_valid = n_valid;
        base_err   = n_err;
        rst_n = 1'b0; #1;
        check("rstmid_stb", io_rd_stb, 0);
        check("rstmid_stall", stall, 0);
        check("rstmid_rdata", rdata, 0);
        tick(); rst_n = 1'b1;
        repeat (4) tick();
        #1;
        check("rstmid_idle_stall", stall, 0);
        check("rstmid_idle_stb", io_rd_stb, 0);
        check("rstmid_no_valid", n_valid - base_valid, 0);
        check("rstmid_no_err", n_err - base_err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
